// File: rtl/soc_ifc_fw_rst_sched_if.sv
// soc_ifc_fw_rst_sched_if
// Groups the requester handshake and the boot-FSM handshake of the
// firmware-update-reset scheduler.
//   req_valid / req_wait_cycles       requester -> scheduler (level request, 8-bit wait per requester)
//   req_grant / req_done / req_err    scheduler -> requester (one-hot, 1-cycle pulses)
//   fw_update_rst / _wait_cycles      scheduler -> boot FSM
//   fw_update_rst_window, cptra_uc_rst_b  boot FSM -> scheduler
//   busy                              scheduler status, high outside IDLE
// The slave modport is the scheduler's view; master is the environment's view.
interface soc_ifc_fw_rst_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_wait_cycles;
  logic [NUM_REQ-1:0]   req_grant;
  logic [NUM_REQ-1:0]   req_done;
  logic [NUM_REQ-1:0]   req_err;
  logic                 fw_update_rst;
  logic [7:0]           fw_update_rst_wait_cycles;
  logic                 fw_update_rst_window;
  logic                 cptra_uc_rst_b;
  logic                 busy;

  modport slave (
    input  req_valid, req_wait_cycles, fw_update_rst_window, cptra_uc_rst_b,
    output req_grant, req_done, req_err, fw_update_rst, fw_update_rst_wait_cycles, busy
  );

  modport master (
    output req_valid, req_wait_cycles, fw_update_rst_window, cptra_uc_rst_b,
    input  req_grant, req_done, req_err, fw_update_rst, fw_update_rst_wait_cycles, busy
  );
endinterface

// File: rtl/soc_ifc_fw_rst_sched.sv
// soc_ifc_fw_rst_sched
// Round-robin arbiter for firmware-update-reset requests. Each grant runs one
// complete fw-update-reset cycle on the boot FSM (request, reset window, uC
// release) and reports done or timeout back to the granted requester.
// Ports:
//   clk          core clock
//   cptra_rst_b  asynchronous active-low reset
//   bus          slave side of soc_ifc_fw_rst_sched_if (requesters + boot FSM)
module soc_ifc_fw_rst_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter logic [7:0]  MIN_WAIT       = 8'd10,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter int unsigned TO_W           = 16
) (
  input  logic                  clk,
  input  logic                  cptra_rst_b,
  soc_ifc_fw_rst_sched_if.slave bus
);

  localparam int unsigned     IDW     = $clog2(NUM_REQ);
  localparam logic [IDW-1:0]  ID_LAST = IDW'(NUM_REQ - 32'd1);
  localparam logic [IDW-1:0]  ID_ONE  = IDW'(32'd1);
  localparam logic [IDW-1:0]  ID_ZERO = {IDW{1'b0}};
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 16'd1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(32'd1);
  localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
  localparam logic [NUM_REQ-1:0] REQ_ZERO = {NUM_REQ{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WINDOW  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  // First requesting index at or above ptr, wrapping around.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] pick;
    logic           hit;
    logic [31:0]    idx;
    pick = ptr;
    hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ((32'(ptr) + k) >= NUM_REQ) ? (32'(ptr) + k - NUM_REQ) : (32'(ptr) + k);
      if (!hit && req[IDW'(idx)]) begin
        hit  = 1'b1;
        pick = IDW'(idx);
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDW-1:0] id);
    logic [NUM_REQ-1:0] oh;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      oh[k] = (IDW'(k) == id);
    end
    return oh;
  endfunction

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == ID_LAST) ? ID_ZERO : (id + ID_ONE);
  endfunction

  // Short wait counts are lifted to the boot FSM's minimum.
  function automatic logic [7:0] clamp_wc(input logic [7:0] wc);
    return (wc < MIN_WAIT) ? MIN_WAIT : wc;
  endfunction

  state_e             r_state, w_state_nxt;
  logic [IDW-1:0]     r_id, w_id_nxt;
  logic [IDW-1:0]     r_ptr, w_ptr_nxt;
  logic [TO_W-1:0]    r_to_cnt, w_to_cnt_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;
  logic [NUM_REQ-1:0] r_err, w_err_nxt;
  logic               r_fw_rst, w_fw_rst_nxt;
  logic [7:0]         r_wc, w_wc_nxt;
  logic               r_busy, w_busy_nxt;

  logic               w_arb_ok;
  logic [IDW-1:0]     w_win_id;
  logic [7:0]         w_win_wc;
  logic               w_to_hit;

  // Arbitration is held off while a cold/warm boot owns the uC reset.
  assign w_arb_ok = (|bus.req_valid) & bus.cptra_uc_rst_b & ~bus.fw_update_rst_window;
  assign w_win_id = rr_pick(bus.req_valid, r_ptr);
  assign w_win_wc = clamp_wc(bus.req_wait_cycles[{w_win_id, 3'b000} +: 8]);
  assign w_to_hit = (r_to_cnt == TO_LAST);

  // Next-state and next-output logic; exit conditions are tested before the timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_id_nxt     = r_id;
    w_ptr_nxt    = r_ptr;
    w_to_cnt_nxt = r_to_cnt;
    w_grant_nxt  = REQ_ZERO;
    w_done_nxt   = REQ_ZERO;
    w_err_nxt    = REQ_ZERO;
    w_fw_rst_nxt = 1'b0;
    w_wc_nxt     = r_wc;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_ok) begin
          w_state_nxt  = ST_ISSUE;
          w_id_nxt     = w_win_id;
          w_wc_nxt     = w_win_wc;
          w_grant_nxt  = to_onehot(w_win_id);
          w_fw_rst_nxt = 1'b1;
          w_to_cnt_nxt = TO_ZERO;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.fw_update_rst_window) begin
          w_state_nxt  = ST_WINDOW;
          w_to_cnt_nxt = TO_ZERO;
        end else if (w_to_hit) begin
          w_state_nxt  = ST_ERR;
          w_err_nxt    = to_onehot(r_id);
        end else begin
          w_fw_rst_nxt = 1'b1;
          w_to_cnt_nxt = r_to_cnt + TO_ONE;
        end
      end
      ST_WINDOW: begin
        if (!bus.fw_update_rst_window) begin
          w_state_nxt  = ST_RELEASE;
          w_to_cnt_nxt = TO_ZERO;
        end else if (w_to_hit) begin
          w_state_nxt  = ST_ERR;
          w_err_nxt    = to_onehot(r_id);
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_ONE;
        end
      end
      ST_RELEASE: begin
        if (bus.cptra_uc_rst_b) begin
          w_state_nxt  = ST_DONE;
          w_done_nxt   = to_onehot(r_id);
        end else if (w_to_hit) begin
          w_state_nxt  = ST_ERR;
          w_err_nxt    = to_onehot(r_id);
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_ONE;
        end
      end
      ST_DONE: begin
        w_ptr_nxt   = next_id(r_id);
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        w_ptr_nxt   = next_id(r_id);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      r_state  <= ST_IDLE;
      r_id     <= ID_ZERO;
      r_ptr    <= ID_ZERO;
      r_to_cnt <= TO_ZERO;
      r_grant  <= REQ_ZERO;
      r_done   <= REQ_ZERO;
      r_err    <= REQ_ZERO;
      r_fw_rst <= 1'b0;
      r_wc     <= MIN_WAIT;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_id     <= w_id_nxt;
      r_ptr    <= w_ptr_nxt;
      r_to_cnt <= w_to_cnt_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_fw_rst <= w_fw_rst_nxt;
      r_wc     <= w_wc_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.req_grant                 = r_grant;
  assign bus.req_done                  = r_done;
  assign bus.req_err                   = r_err;
  assign bus.fw_update_rst             = r_fw_rst;
  assign bus.fw_update_rst_wait_cycles = r_wc;
  assign bus.busy                      = r_busy;

endmodule
